// File: rtl/pic_inta_sequencer.sv
// 8259 CPU-side sequencer: priority resolution against ISR, INT generation,
// 8086-mode two-pulse INTA handshake with vector drive, and EOI handling.
module pic_inta_sequencer #(
    parameter int NUM_IR   = 8,
    parameter int LP_RESET = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IR-1:0] irr,
    input  logic              inta_n,
    input  logic [4:0]        vector_base,
    input  logic              aeoi,
    input  logic              auto_rotate,
    input  logic              eoi_cmd,
    input  logic              eoi_specific,
    input  logic [2:0]        eoi_level,
    output logic              int_out,
    output logic [NUM_IR-1:0] irr_clear,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic              spurious
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK1 = 2'd2;
    localparam logic [1:0] S_ACK2 = 2'd3;
    localparam logic [2:0] LP_INIT = 3'(LP_RESET);

    logic [1:0] state_q, state_d;
    logic       int_out_q, int_out_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] irr_clear_q, irr_clear_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic       spurious_q, spurious_d;
    logic [2:0] lp_q, lp_d;
    logic       inta_q;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;

    logic       fall_s, rise_s;
    logic [3:0] cand_pick_s, cur_pick_s;
    logic [2:0] cand_s, cur_s, eoi_tgt_s;
    logic       req_ok_s, eoi_hit_s, first_ack_s;
    logic [7:0] isr_set_s, isr_clr_s;

    // Level lp+1 has rank 0 (highest); returns {valid, level} of the best set bit.
    function automatic logic [3:0] pick_highest(input logic [7:0] vec, input logic [2:0] lp);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            lvl = lp + 3'd1 + 3'(k);
            if (vec[lvl]) begin
                res = {1'b1, lvl};
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

    assign fall_s      = inta_q & ~inta_n;
    assign rise_s      = ~inta_q & inta_n;
    assign cand_pick_s = pick_highest(irr, lp_q);
    assign cur_pick_s  = pick_highest(isr_q, lp_q);
    assign cand_s      = cand_pick_s[2:0];
    assign cur_s       = cur_pick_s[2:0];
    assign req_ok_s    = cand_pick_s[3] &
                         (~cur_pick_s[3] | (prio_rank(cand_s, lp_q) < prio_rank(cur_s, lp_q)));
    assign eoi_tgt_s   = eoi_specific ? eoi_level : cur_s;
    assign eoi_hit_s   = eoi_cmd & isr_q[eoi_tgt_s];

    // Handshake FSM plus ISR/priority update; ISR set beats any clear of the same bit.
    always_comb begin
        state_d     = state_q;
        int_out_d   = int_out_q;
        irr_clear_d = 8'd0;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        spurious_d  = 1'b0;
        lp_d        = lp_q;
        lvl_d       = lvl_q;
        spur_d      = spur_q;
        first_ack_s = 1'b0;
        isr_set_s   = 8'd0;
        isr_clr_s   = 8'd0;
        case (state_q)
            S_IDLE: begin
                int_out_d = 1'b0;
                if (fall_s) begin
                    first_ack_s = 1'b1;
                end else if (req_ok_s) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                int_out_d = 1'b1;
                if (fall_s) begin
                    first_ack_s = 1'b1;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_ACK1: begin
                int_out_d = 1'b0;
                if (fall_s) begin
                    data_out_d = {vector_base, lvl_q};
                    data_oe_d  = 1'b1;
                    state_d    = S_ACK2;
                end else begin
                    data_oe_d  = 1'b0;
                end
            end
            S_ACK2: begin
                int_out_d = 1'b0;
                if (rise_s) begin
                    data_oe_d = 1'b0;
                    state_d   = S_IDLE;
                    if (aeoi && !spur_q) begin
                        isr_clr_s = 8'd1 << lvl_q;
                        lp_d      = auto_rotate ? lvl_q : lp_q;
                    end else begin
                        isr_clr_s = 8'd0;
                    end
                end else begin
                    data_oe_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                int_out_d = 1'b0;
            end
        endcase
        // A fall with nothing eligible acknowledges as spurious on level 7.
        if (first_ack_s) begin
            int_out_d = 1'b0;
            state_d   = S_ACK1;
            spur_d    = ~req_ok_s;
            if (req_ok_s) begin
                lvl_d       = cand_s;
                isr_set_s   = 8'd1 << cand_s;
                irr_clear_d = 8'd1 << cand_s;
            end else begin
                lvl_d      = 3'd7;
                spurious_d = 1'b1;
            end
        end else begin
            spur_d = spur_q;
        end
        if (eoi_hit_s) begin
            isr_clr_s = isr_clr_s | (8'd1 << eoi_tgt_s);
            lp_d      = auto_rotate ? eoi_tgt_s : lp_d;
        end else begin
            isr_clr_s = isr_clr_s;
        end
        isr_d = (isr_q & ~isr_clr_s) | isr_set_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            int_out_q   <= 1'b0;
            isr_q       <= 8'd0;
            irr_clear_q <= 8'd0;
            data_out_q  <= 8'd0;
            data_oe_q   <= 1'b0;
            spurious_q  <= 1'b0;
            lp_q        <= LP_INIT;
            inta_q      <= 1'b1;
            lvl_q       <= 3'd0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_out_q   <= int_out_d;
            isr_q       <= isr_d;
            irr_clear_q <= irr_clear_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            spurious_q  <= spurious_d;
            lp_q        <= lp_d;
            inta_q      <= inta_n;
            lvl_q       <= lvl_d;
            spur_q      <= spur_d;
        end
    end

    assign int_out   = int_out_q;
    assign irr_clear = irr_clear_q;
    assign isr       = isr_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign spurious  = spurious_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Randomized bench for pic_inta_sequencer against a rank-arithmetic reference
// model of the 8259 priority, ISR and EOI rules.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irr;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi, auto_rotate, eoi_cmd, eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] irr_clear, isr, data_out;
    logic       data_oe, spurious;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_isr;
    int         m_lp;
    logic [7:0] last_vec;

    pic_inta_sequencer #(.NUM_IR(8), .LP_RESET(7)) dut (
        .clk(clk), .reset_n(reset_n), .irr(irr), .inta_n(inta_n),
        .vector_base(vector_base), .aeoi(aeoi), .auto_rotate(auto_rotate),
        .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .int_out(int_out), .irr_clear(irr_clear), .isr(isr),
        .data_out(data_out), .data_oe(data_oe), .spurious(spurious)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Priority rank: lp+1 ranks 0 (best), lp ranks 7 (worst).
    function automatic int m_rank(input int lvl);
        return (((lvl - m_lp - 1) % 8) + 8) % 8;
    endfunction

    function automatic int m_best(input logic [7:0] v);
        int best = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (best < 0 || m_rank(i) < m_rank(best))) best = i;
        return best;
    endfunction

    function automatic bit m_req_ok(input logic [7:0] v);
        int c = m_best(v);
        int u = m_best(m_isr);
        return (c >= 0) && (u < 0 || m_rank(c) < m_rank(u));
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_isr = 8'h00;
        m_lp  = 7;
        check_eq("rst_int", 32'(int_out), 32'd0);
        check_eq("rst_isr", 32'(isr), 32'd0);
        check_eq("rst_oe", 32'(data_oe), 32'd0);
        check_eq("rst_dout", 32'(data_out), 32'd0);
        check_eq("rst_clr", 32'(irr_clear), 32'd0);
        check_eq("rst_spur", 32'(spurious), 32'd0);
    endtask

    task automatic raise_irr(input logic [7:0] v);
        irr = v;
        tick();
        check_eq("int_lat1", 32'(int_out), 32'd0);
        tick();
        check_eq("int_lat2", 32'(int_out), 32'(m_req_ok(v)));
    endtask

    task automatic do_eoi(input bit spec, input int lvl);
        int tgt;
        tgt = spec ? lvl : m_best(m_isr);
        if (tgt >= 0 && m_isr[tgt]) begin
            m_isr[tgt] = 1'b0;
            if (auto_rotate) m_lp = tgt;
        end
        eoi_cmd = 1'b1; eoi_specific = spec; eoi_level = 3'(lvl);
        tick();
        eoi_cmd = 1'b0;
        check_eq("eoi_isr", 32'(isr), 32'(m_isr));
    endtask

    // Full two-pulse acknowledge, optionally with an EOI strobed on the first fall.
    task automatic do_ack(input bit with_eoi, input bit eoi_spec_v, input int eoi_lvl_v, output int lvl);
        bit         ok;
        int         tgt;
        logic [7:0] set_m, eoi_m;
        ok    = m_req_ok(irr);
        lvl   = ok ? m_best(irr) : 7;
        set_m = ok ? 8'(1 << lvl) : 8'h00;
        eoi_m = 8'h00;
        if (with_eoi) begin
            tgt = eoi_spec_v ? eoi_lvl_v : m_best(m_isr);
            if (tgt >= 0 && m_isr[tgt]) begin
                eoi_m = 8'(1 << tgt);
                if (auto_rotate) m_lp = tgt;
            end
        end
        eoi_cmd = with_eoi; eoi_specific = eoi_spec_v; eoi_level = 3'(eoi_lvl_v);
        inta_n = 1'b0;
        tick();
        eoi_cmd = 1'b0;
        m_isr = (m_isr & ~eoi_m) | set_m;
        check_eq("ack1_clr", 32'(irr_clear), 32'(set_m));
        check_eq("ack1_spur", 32'(spurious), 32'(!ok));
        check_eq("ack1_int", 32'(int_out), 32'd0);
        check_eq("ack1_isr", 32'(isr), 32'(m_isr));
        irr = irr & ~set_m;
        tick();
        check_eq("clr_pulse", 32'(irr_clear), 32'd0);
        check_eq("spur_pulse", 32'(spurious), 32'd0);
        inta_n = 1'b1;
        tick();
        check_eq("ack1_oe", 32'(data_oe), 32'd0);
        tick();
        inta_n = 1'b0;
        tick();
        last_vec = data_out;
        check_eq("ack2_oe", 32'(data_oe), 32'd1);
        check_eq("ack2_vec", 32'(data_out), 32'({vector_base, 3'(lvl)}));
        tick();
        check_eq("ack2_oe_hold", 32'(data_oe), 32'd1);
        inta_n = 1'b1;
        tick();
        if (aeoi && ok) begin
            m_isr[lvl] = 1'b0;
            if (auto_rotate) m_lp = lvl;
        end
        check_eq("rise_oe", 32'(data_oe), 32'd0);
        check_eq("rise_isr", 32'(isr), 32'(m_isr));
        check_eq("rise_dout", 32'(data_out), 32'(last_vec));
    endtask

    initial begin
        int lvl;
        logic [7:0] v;
        reset_n = 1'b0; irr = 8'h00; inta_n = 1'b1; vector_base = 5'b01000;
        aeoi = 1'b0; auto_rotate = 1'b0; eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        tick();
        do_reset();

        // Basic ack of IR3
        raise_irr(8'h08);
        do_ack(1'b0, 1'b0, 0, lvl);
        check_eq("t1_vec", 32'(last_vec), 32'h43);
        irr = 8'h00;
        do_eoi(1'b0, 0);

        // Nesting: IR6 held off, IR1 nests over IR4
        raise_irr(8'h10);
        do_ack(1'b0, 1'b0, 0, lvl);
        raise_irr(8'h40);
        check_eq("t2_ir6_blocked", 32'(int_out), 32'd0);
        raise_irr(8'h02);
        do_ack(1'b0, 1'b0, 0, lvl);
        check_eq("t2_isr12", 32'(isr), 32'h12);
        irr = 8'h00;
        do_eoi(1'b0, 0);
        check_eq("t2_isr10", 32'(isr), 32'h10);
        do_eoi(1'b0, 0);

        // Spurious: request vanishes before INTA
        raise_irr(8'h04);
        irr = 8'h00;
        tick();
        check_eq("t3_int_hold", 32'(int_out), 32'd1);
        do_ack(1'b0, 1'b0, 0, lvl);
        check_eq("t3_vec_lo", 32'(last_vec[2:0]), 32'd7);

        // AEOI with rotation
        aeoi = 1'b1; auto_rotate = 1'b1;
        raise_irr(8'h04);
        do_ack(1'b0, 1'b0, 0, lvl);
        check_eq("t4_isr0", 32'(isr), 32'd0);
        irr = 8'h00;
        tick();
        raise_irr(8'h09);
        do_ack(1'b0, 1'b0, 0, lvl);
        check_eq("t4_vec_lo", 32'(last_vec[2:0]), 32'd3);
        irr = 8'h00;
        aeoi = 1'b0; auto_rotate = 1'b0;
        tick();

        // Specific EOI coinciding with first INTA fall
        do_reset();
        raise_irr(8'h20);
        do_ack(1'b0, 1'b0, 0, lvl);
        irr = 8'h00;
        tick();
        raise_irr(8'h01);
        do_ack(1'b1, 1'b1, 5, lvl);
        check_eq("t5_isr01", 32'(isr), 32'h01);
        irr = 8'h00;
        do_eoi(1'b0, 0);

        // Reset during ACK1
        raise_irr(8'h02);
        inta_n = 1'b0;
        tick();
        irr = 8'h00; inta_n = 1'b1;
        tick();
        tick();
        do_reset();
        do_ack(1'b0, 1'b0, 0, lvl);
        check_eq("t6_vec_lo", 32'(last_vec[2:0]), 32'd7);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            vector_base = 5'($urandom);
            aeoi        = 1'($urandom_range(0, 1));
            auto_rotate = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) do_eoi(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            raise_irr(v);
            if (m_req_ok(v) && $urandom_range(0, 4) == 0) begin
                irr = 8'h00;
                tick();
            end
            do_ack(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), lvl);
            irr = 8'h00;
            tick();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- CPU-facing end of the 8259 interrupt path. The IRR block latches requests; this block resolves priority against the in-service register (ISR) and raises INT to the CPU.
- Runs the 8086-mode two-pulse INTA handshake: sets ISR, tells the IRR block to drop the acknowledged request, and drives the vector byte on the data bus.
- Also executes EOI commands from the control logic.
- Sits between the IRR block, the control logic and the data bus buffer.

Parameters:
- NUM_IR, 8, number of interrupt levels; fixed at 8, with a 3-bit level code.
- LP_RESET, 7, lowest-priority level after reset; the default makes IR0 highest.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- irr  in  8  masked pending requests from the IRR block.
- inta_n  in  1  CPU acknowledge, active low, already synchronised to clk.
- vector_base  in  5  ICW2 T7..T3.
- aeoi  in  1  automatic-EOI mode.
- auto_rotate  in  1  rotate priority on each EOI (automatic or commanded).
- eoi_cmd  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  when 1, the EOI targets eoi_level.
- eoi_level  in  3  level for specific EOI.
- int_out  out  1  INT to CPU.
- irr_clear  out  8  one-cycle pulse clearing the acknowledged request bit.
- isr  out  8  in-service register.
- data_out  out  8  vector byte.
- data_oe  out  1  data bus drive enable.
- spurious  out  1  one-cycle pulse when a spurious acknowledge occurs.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, int_out=0, isr=0, irr_clear=0, data_out=0, data_oe=0, spurious=0, lp=LP_RESET, inta_q=1.
- INTA edge detection: inta_q <= inta_n. fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- Priority order: lp+1 is highest, then wrapping mod 8 up to lp, which is lowest.
  - cand = highest-priority set bit of irr.
  - cur = highest-priority set bit of isr.
  - req_ok = a cand exists AND (isr==0 OR cand has strictly higher priority than cur).
- State IDLE:
  - int_out=0.
  - req_ok → REQ, with int_out=1 from the next cycle.
  - fall → handled exactly as fall in REQ.
- State REQ:
  - int_out=1.
  - req_ok drops before fall → int_out stays 1 and the state stays REQ; the ack is resolved at fall.
  - On fall, latch L=cand if req_ok, else L=7 and spurious.
  - Non-spurious: isr[L]<=1 and irr_clear[L]=1 for one cycle.
  - Spurious: no ISR change, spurious pulses.
  - int_out<=0, go to ACK1.
- State ACK1:
  - Wait for the second fall; data_oe=0.
  - On fall: data_out<={vector_base,L}, data_oe<=1, go to ACK2.
- State ACK2:
  - data_oe=1 while inta_n is low.
  - On rise: data_oe<=0.
  - If aeoi and not spurious: isr[L]<=0; if auto_rotate, also lp<=L.
  - Go to IDLE. data_out holds its value until the next ack.
- Latency:
  - irr rising to int_out=1: 2 clk (1 compare cycle, then the registered output).
  - First INTA fall to isr set: 1 clk after fall is detected.
- EOI (eoi_cmd=1, any state):
  - Non-specific: clear isr[cur].
  - Specific: clear isr[eoi_level].
  - If auto_rotate: lp<=the cleared level.
  - No-op if the target bit is 0 or isr==0.
- Simultaneous EOI and first-INTA set in the same cycle:
  - EOI target is computed from the pre-update isr; both updates apply.
  - If both hit the same bit, the set wins.
- Simultaneous AEOI clear and eoi_cmd: both clears apply; lp takes the EOI-command level.
- Nesting: a higher-priority cand may raise INT while isr is non-zero. Equal or lower priority is held off until the blocking ISR bit clears.
- reset_n low mid-handshake: all state returns to reset values on that edge. Later INTA pulses are treated as new first pulses.

Test Plan:
1. Basic ack:
   - Stimulus: vector_base=5'b01000, irr=8'h08, two INTA pulses.
   - Response: int_out=1 two cycles after irr; isr=8'h08 and irr_clear=8'h08 after the first fall; data_out=8'h43 with data_oe=1 during the second pulse; int_out=0 after the first fall.
2. Priority and nesting:
   - Stimulus: ack irr=8'h10 so isr=8'h10; then raise irr bit 6 (irr=8'h40), later bit 1 (irr=8'h02).
   - Response: int_out stays 0 for bit 6; int_out goes 1 for bit 1; after ack, isr=8'h12.
   - Then non-specific EOI → isr=8'h10.
3. Spurious:
   - Stimulus: irr=8'h04 raises INT; irr drops to 0 before the first INTA.
   - Response: spurious pulses; isr stays 8'h00; vector = {vector_base,3'b111}.
4. AEOI with rotation:
   - Stimulus: aeoi=1, auto_rotate=1, ack IR2.
   - Response: isr=0 after the second INTA rise; lp=2, so IR3 is now highest. With irr=8'h09, the ack selects IR3 (data_out low bits 3'b011).
5. Specific EOI with simultaneous ack:
   - Stimulus: isr=8'h20; eoi_specific=1, eoi_level=5, strobed in the same cycle as the first fall for IR0.
   - Response: isr=8'h01.
6. Reset mid-handshake:
   - Stimulus: reset_n=0 in ACK1.
   - Response: isr=0, int_out=0, data_oe=0, state IDLE. The next INTA fall with irr=0 gives a spurious response.
